// File: rtl/overlay_sequencer.sv
// Game-flow sequencer for the racing overlay: IDLE -> PLAY -> CRASH/WIN/LOST,
// producing registered layer enables, freeze, blink and remaining-lives outputs.
module overlay_sequencer #(
    parameter int LIVES        = 3,
    parameter int CRASH_FRAMES = 90,
    parameter int END_FRAMES   = 180,
    parameter int BLINK_PERIOD = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic       start_key,
    input  logic       crash_event,
    input  logic       fuel_empty,
    input  logic       win_event,
    output logic       idle_request,
    output logic       win_show,
    output logic       lost_show,
    output logic       player_hide,
    output logic       freeze,
    output logic [2:0] lives,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLAY  = 3'd1,
        S_CRASH = 3'd2,
        S_WIN   = 3'd3,
        S_LOST  = 3'd4
    } state_t;

    localparam logic [2:0] LIVES3 = 3'(LIVES);
    localparam logic [7:0] CF8    = 8'(CRASH_FRAMES);
    localparam logic [7:0] EF8    = 8'(END_FRAMES);
    localparam logic [7:0] BP8    = 8'(BLINK_PERIOD);

    state_t     state_q, nxt;
    logic [7:0] frame_cnt, nxt_frame;
    logic [7:0] blink_cnt, nxt_blink;
    logic       nxt_hide;
    logic [2:0] nxt_lives;

    assign state = state_q;

    // Every transition clears both counters, so a new state always starts at frame 0.
    always_comb begin
        nxt       = state_q;
        nxt_frame = frame_cnt;
        nxt_blink = blink_cnt;
        nxt_hide  = player_hide;
        nxt_lives = lives;
        case (state_q)
            S_IDLE: begin
                if (start_key) begin
                    nxt       = S_PLAY;
                    nxt_lives = LIVES3;
                    nxt_frame = 8'd0;
                    nxt_blink = 8'd0;
                end
            end
            S_PLAY: begin
                if (win_event) begin
                    nxt       = S_WIN;
                    nxt_frame = 8'd0;
                    nxt_blink = 8'd0;
                end else if (fuel_empty) begin
                    nxt       = S_LOST;
                    nxt_frame = 8'd0;
                    nxt_blink = 8'd0;
                end else if (crash_event) begin
                    nxt       = S_CRASH;
                    nxt_lives = (lives == 3'd0) ? 3'd0 : lives - 3'd1;
                    nxt_frame = 8'd0;
                    nxt_blink = 8'd0;
                    nxt_hide  = 1'b1;
                end
            end
            S_CRASH: begin
                if (startOfFrame) begin
                    if (frame_cnt + 8'd1 == CF8) begin
                        nxt       = (lives == 3'd0) ? S_LOST : S_PLAY;
                        nxt_frame = 8'd0;
                        nxt_blink = 8'd0;
                        nxt_hide  = 1'b0;
                    end else begin
                        nxt_frame = frame_cnt + 8'd1;
                        if (blink_cnt + 8'd1 == BP8) begin
                            nxt_blink = 8'd0;
                            nxt_hide  = ~player_hide;
                        end else begin
                            nxt_blink = blink_cnt + 8'd1;
                        end
                    end
                end
            end
            S_WIN, S_LOST: begin
                if (startOfFrame) begin
                    if (frame_cnt + 8'd1 == EF8) begin
                        nxt       = S_IDLE;
                        nxt_frame = 8'd0;
                        nxt_blink = 8'd0;
                    end else begin
                        nxt_frame = frame_cnt + 8'd1;
                    end
                end
            end
            default: begin
                nxt       = S_IDLE;
                nxt_frame = 8'd0;
                nxt_blink = 8'd0;
                nxt_hide  = 1'b0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change together with state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            frame_cnt    <= 8'd0;
            blink_cnt    <= 8'd0;
            lives        <= LIVES3;
            player_hide  <= 1'b0;
            idle_request <= 1'b1;
            freeze       <= 1'b1;
            win_show     <= 1'b0;
            lost_show    <= 1'b0;
        end else begin
            state_q      <= nxt;
            frame_cnt    <= nxt_frame;
            blink_cnt    <= nxt_blink;
            lives        <= nxt_lives;
            player_hide  <= nxt_hide && (nxt == S_CRASH);
            idle_request <= (nxt == S_IDLE);
            freeze       <= (nxt != S_PLAY);
            win_show     <= (nxt == S_WIN);
            lost_show    <= (nxt == S_LOST);
        end
    end

endmodule

// File: doc/overlay_sequencer.md
OVERLAY_SEQUENCER -- requirements
Module: overlay_sequencer

Interface
REQ-001 Parameter LIVES, default 3, crashes allowed before LOST; legal 1..7.
REQ-002 Parameter CRASH_FRAMES, default 90, frame length of crash-blink phase; legal 1..255.
REQ-003 Parameter END_FRAMES, default 180, frame length of WIN/LOST overlay display; legal 1..255.
REQ-004 Parameter BLINK_PERIOD, default 8, frames per player-hide toggle during crash; legal 1..255.
REQ-005 clk  in  1  single system clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 startOfFrame  in  1  one-cycle pulse, once per VGA frame.
REQ-008 start_key  in  1  one-cycle pulse, player start request.
REQ-009 crash_event  in  1  one-cycle pulse, player car collided with car/truck/hole.
REQ-010 fuel_empty  in  1  level, fuel gauge reached zero.
REQ-011 win_event  in  1  one-cycle pulse, finish distance reached.
REQ-012 idle_request  out  1  blanks all sprite layers in the objects mux (background only).
REQ-013 win_show  out  1  enables WIN overlay layer.
REQ-014 lost_show  out  1  enables LOST overlay layer.
REQ-015 player_hide  out  1  suppresses red-car drawing request (blink).
REQ-016 freeze  out  1  halts road scroll, traffic and fuel consumption.
REQ-017 lives  out  3  remaining lives.
REQ-018 state  out  3  encoded state: IDLE=0, PLAY=1, CRASH=2, WIN=3, LOST=4.

Function
REQ-019 All outputs shall be registered; outputs shall reflect new state on the cycle after the edge on which the transition is taken (1-cycle latency).
REQ-020 IDLE: idle_request=1, freeze=1, others 0; start_key -> PLAY, lives loaded with LIVES, frame counter cleared.
REQ-021 PLAY: idle_request=0, freeze=0; on same-cycle coincidence priority shall be win_event > fuel_empty > crash_event.
REQ-022 PLAY: win_event -> WIN; fuel_empty=1 -> LOST; crash_event -> CRASH with lives decremented by 1, frame counter and blink counter cleared, player_hide=1.
REQ-023 CRASH: freeze=1; frame counter shall increment only on startOfFrame; player_hide shall toggle each time blink counter reaches BLINK_PERIOD (blink counter then returns to 0).
REQ-024 CRASH exit: on the startOfFrame at which frame counter reaches CRASH_FRAMES -> LOST if lives==0, else PLAY; player_hide shall be 0 on exit.
REQ-025 CRASH: crash_event, win_event, fuel_empty and start_key shall be ignored.
REQ-026 WIN: win_show=1, freeze=1; LOST: lost_show=1, freeze=1; each shall return to IDLE on the startOfFrame at which frame counter reaches END_FRAMES; start_key ignored meanwhile.
REQ-027 win_show and lost_show shall never be 1 simultaneously; idle_request=1 only in IDLE.
REQ-028 lives shall saturate at 0 (never wrap); counters 8 bits, cleared on every state entry.
REQ-029 startOfFrame coinciding with a state-entry cycle shall not count toward the new state's frame count.
REQ-030 Unused state encodings shall return to IDLE on the next cycle.

Reset
REQ-031 reset sampled high on a clk edge shall force state=IDLE, idle_request=1, freeze=1, win_show=0, lost_show=0, player_hide=0, lives=LIVES, all counters 0, regardless of current state or pending events.
REQ-032 reset asserted mid-CRASH/WIN/LOST shall abort the sequence with no residual overlay on the following cycle.

Verification
REQ-033 reset, start_key pulse -> state=1 next cycle, idle_request=0, lives=3.
REQ-034 PLAY, crash_event, 90 startOfFrame pulses (BLINK_PERIOD=8) -> player_hide toggles 11 times, state=1 after 90th pulse, lives=2.
REQ-035 Three crashes with LIVES=3 -> after third CRASH_FRAMES elapse state=4, lost_show=1; 180 frames later state=0, idle_request=1.
REQ-036 PLAY, win_event and crash_event same cycle -> state=3, lives unchanged, win_show=1.
REQ-037 PLAY, fuel_empty=1 -> state=4; crash_event during LOST -> no change; reset mid-LOST -> state=0, lost_show=0 next cycle.
REQ-038 WIN, start_key pulses before timeout -> state remains 3 until 180th startOfFrame.
